// File: rtl/sign_mag_pkg.sv
// sign_mag_pkg: shared types and helpers for the serial sign-magnitude add/sub
//   state_e     - control FSM states
//   calc_n()    - number of digit cycles per pass, (WIDTH-1)/DIGIT
//   eff_sub_f() - effective operation: 1 when magnitudes must be subtracted
package sign_mag_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    function automatic int calc_n(input int width, input int digit);
        return (width - 1) / digit;
    endfunction

    function automatic logic eff_sub_f(input logic sign_a, input logic sign_b, input logic add_sub);
        return sign_a ^ sign_b ^ add_sub;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit adder with carry in/out
//   i_a, i_b - addend digits
//   i_cin    - carry in
//   o_sum    - sum digit
//   o_cout   - carry out
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/sign_mag_serial_addsub.sv
// sign_mag_serial_addsub: multi-cycle sign-magnitude adder/subtractor, DIGIT bits per cycle
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   a, b, add_sub       - sign-magnitude operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready - result handshake (result held until accepted)
//   result, overflow    - sign-magnitude result, lost magnitude carry on effective add
//   busy                - high while an operation is in flight
module sign_mag_serial_addsub
    import sign_mag_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);

    localparam int MAG_W = WIDTH - 1;
    localparam int N     = calc_n(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           r_state;
    logic [MAG_W-1:0] r_a_mag;
    logic [MAG_W-1:0] r_b_mag;
    logic [MAG_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_sign;
    logic             r_eff_sub;
    logic             r_carry;
    logic             r_fixed;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;

    logic [DIGIT-1:0]       w_add_a;
    logic [DIGIT-1:0]       w_add_b;
    logic [DIGIT-1:0]       w_sum;
    logic                   w_cout;
    logic [MAG_W+DIGIT-1:0] w_shift;
    logic [MAG_W-1:0]       w_acc_next;
    logic                   w_eff_sub;
    logic                   w_sign;

    // One adder serves both passes: CALC adds operand digits, FIX adds 1 to the inverted accumulator digit
    assign w_add_a = (r_state == FIX) ? ~r_acc[DIGIT-1:0] : r_a_mag[DIGIT-1:0];
    assign w_add_b = (r_state == FIX) ? '0 :
                     r_eff_sub ? ~r_b_mag[DIGIT-1:0] : r_b_mag[DIGIT-1:0];

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    // Accumulator is a shift register: the new digit enters at the top and the
    // lowest digit is consumed, so after N steps every digit is back in place
    assign w_shift    = {w_sum, r_acc};
    assign w_acc_next = w_shift[MAG_W+DIGIT-1:DIGIT];
    assign w_eff_sub  = eff_sub_f(a[WIDTH-1], b[WIDTH-1], add_sub);
    // A complemented result takes the opposite sign; a zero magnitude is always positive
    assign w_sign     = (|r_acc) & (r_fixed ? ~r_a_sign : r_a_sign);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_mag     <= '0;
            r_b_mag     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_a_sign    <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_carry     <= 1'b0;
            r_fixed     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a_mag   <= a[MAG_W-1:0];
                    r_b_mag   <= b[MAG_W-1:0];
                    r_a_sign  <= a[WIDTH-1];
                    r_eff_sub <= w_eff_sub;
                    r_carry   <= w_eff_sub;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_fixed   <= 1'b0;
                    r_state   <= CALC;
                end
                CALC: begin
                    r_a_mag <= r_a_mag >> DIGIT;
                    r_b_mag <= r_b_mag >> DIGIT;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        // No carry out of A + ~B + 1 means |A| < |B|: negate the difference
                        if (r_eff_sub && !w_cout) begin
                            r_state <= FIX;
                            r_carry <= 1'b1;
                            r_fixed <= 1'b1;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                FIX: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= {w_sign, r_acc};
                        r_overflow  <= !r_eff_sub && r_carry;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sign_mag_serial_addsub.sv
// tb_sign_mag_serial_addsub: directed bench for sign_mag_serial_addsub (DIGIT=1 and DIGIT=7 instances)
module tb_sign_mag_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_valid7 = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       add_sub = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, overflow, busy;
    logic [7:0] result;
    logic       in_ready7, out_valid7, overflow7, busy7;
    logic [7:0] result7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sign_mag_serial_addsub #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .add_sub(add_sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    sign_mag_serial_addsub #(.WIDTH(8), .DIGIT(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
        .a(a), .b(b), .add_sub(add_sub), .out_valid(out_valid7), .out_ready(out_ready),
        .result(result7), .overflow(overflow7), .busy(busy7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts posedges after the accept edge until out_valid is seen, bounded
    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? out_valid7 : out_valid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input bit sel, input logic [7:0] ia, input logic [7:0] ib, input logic op,
                          input logic [7:0] er, input logic eo, input int elat, input string tag);
        int lat;
        @(negedge clk);
        a = ia;
        b = ib;
        add_sub = op;
        out_ready = 1'b1;
        if (sel) in_valid7 = 1'b1;
        else in_valid = 1'b1;
        check({tag, ".in_ready"}, sel ? in_ready7 : in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid7 = 1'b0;
        a = ~ia;
        b = 8'h7f;
        add_sub = ~op;
        wait_valid(sel, lat);
        check({tag, ".latency"}, lat, elat);
        check({tag, ".result"}, sel ? result7 : result, er);
        check({tag, ".overflow"}, sel ? overflow7 : overflow, eo);
        @(posedge clk);
        #1;
        check({tag, ".released"}, sel ? {out_valid7, in_ready7} : {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int lat;
        #3;
        check("reset.out_valid", out_valid, 0);
        check("reset.in_ready", in_ready, 1);
        check("reset.busy", busy, 0);
        check("reset.result", result, 0);
        check("reset.overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 8,  "add_5_3");
        run_op(0, 8'h03, 8'h05, 1'b1, 8'h82, 1'b0, 15, "sub_3_5_fix");
        run_op(0, 8'h85, 8'h85, 1'b1, 8'h00, 1'b0, 8,  "sub_self_zero");
        run_op(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 8,  "negzero_add");
        run_op(0, 8'h64, 8'h32, 1'b0, 8'h16, 1'b1, 8,  "ovf_pos");
        run_op(0, 8'hE4, 8'hB2, 1'b0, 8'h96, 1'b1, 8,  "ovf_neg");
        run_op(0, 8'h05, 8'h83, 1'b0, 8'h02, 1'b0, 8,  "add_mixed_sign");
        run_op(0, 8'h83, 8'h05, 1'b0, 8'h02, 1'b0, 15, "neg_plus_pos_fix");

        // Back-pressure: result held, second request waits for release
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        add_sub = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h01;
        wait_valid(0, lat);
        check("hold.latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold.out_valid", out_valid, 1);
            check("hold.result", result, 8'h08);
            check("hold.overflow", overflow, 0);
            check("hold.in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold.release", {out_valid, in_ready, busy}, 3'b010);
        @(posedge clk);
        #1;
        check("hold.second_accept", {in_ready, busy}, 2'b01);
        in_valid = 1'b0;
        wait_valid(0, lat);
        check("hold.second_latency", lat, 8);
        check("hold.second_result", result, 8'h02);
        @(posedge clk);
        #1;

        // Reset during CALC aborts without a result
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        add_sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort.async", {out_valid, busy, in_ready}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.no_result", out_valid, 0);
        run_op(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8, "after_abort");

        run_op(1, 8'h03, 8'h05, 1'b1, 8'h82, 1'b0, 3, "d7_sub_fix");
        run_op(1, 8'h64, 8'h32, 1'b0, 8'h16, 1'b1, 2, "d7_ovf");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
